// File: rtl/mem_dump_uart_tx.sv
// Burst-reads a block of data RAM words into a local buffer, then streams
// them byte by byte to a UART transmitter with a fixed inter-byte gap.
module mem_dump_uart_tx #(
    parameter  int ADDR_W       = 32,
    parameter  int DATA_W       = 32,
    parameter  int MAX_WORDS    = 8,
    parameter  int GAP_CYCLES   = 12432,
    parameter  int USE_TX_READY = 1,
    localparam int CNT_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rearm,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_nwords,
    input  logic              cfg_msb_first,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int BYTES = DATA_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        GAP
    } state_t;

    state_t state;

    logic             armed;
    logic             msb_q;
    logic             cap_pend;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] iss_cnt;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] word_idx;
    logic [BI_W-1:0]  byte_idx;
    logic [GAP_W-1:0] gap_cnt;

    logic [DATA_W-1:0] wbuf [MAX_WORDS];

    logic [CNT_W-1:0]  n_req;
    logic [DATA_W-1:0] cur_word;
    logic [BI_W-1:0]   sel;
    logic [7:0]        cur_byte;
    logic              last_byte;
    logic              last_word;
    logic              can_issue;
    logic              buf_we;
    logic [GAP_W-1:0]  gap_lim;

    // Requested word count clamped to the buffer depth.
    assign n_req = (cfg_nwords > CNT_W'(MAX_WORDS)) ?
                   CNT_W'(MAX_WORDS) : cfg_nwords;

    assign cur_word  = wbuf[word_idx[IDX_W-1:0]];
    assign sel       = msb_q ? (BI_W'(BYTES - 1) - byte_idx) : byte_idx;
    assign cur_byte  = cur_word[{sel, 3'b000} +: 8];
    assign last_byte = (byte_idx == BI_W'(BYTES - 1));
    assign last_word = (word_idx == (n_q - CNT_W'(1)));
    assign can_issue = tx_ready || (USE_TX_READY == 0);
    assign buf_we    = (state == FETCH) && cap_pend;

    // The final byte waits one extra cycle so done lands where the next
    // byte strobe would otherwise have appeared.
    assign gap_lim = (last_byte && last_word) ?
                     GAP_W'(GAP_CYCLES) : GAP_W'(GAP_CYCLES - 1);

    // Word buffer: capture RAM data the cycle after each read strobe.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            wbuf[wr_idx[IDX_W-1:0]] <= mem_rdata;
        end
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            armed    <= 1'b1;
            msb_q    <= 1'b0;
            cap_pend <= 1'b0;
            n_q      <= '0;
            iss_cnt  <= '0;
            wr_idx   <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            mem_req  <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            tx_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start && armed) begin
                        msb_q <= cfg_msb_first;
                        n_q   <= n_req;
                        armed <= 1'b0;
                        if (n_req == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            mem_req  <= 1'b1;
                            mem_en   <= 1'b1;
                            mem_addr <= cfg_base;
                            iss_cnt  <= CNT_W'(1);
                            wr_idx   <= '0;
                            cap_pend <= 1'b0;
                        end
                    end
                end

                FETCH: begin
                    cap_pend <= mem_en;
                    if (mem_en) begin
                        if (iss_cnt == n_q) begin
                            mem_en  <= 1'b0;
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(BYTES);
                            iss_cnt  <= iss_cnt + CNT_W'(1);
                        end
                    end
                    if (cap_pend) begin
                        wr_idx <= wr_idx + CNT_W'(1);
                        if (wr_idx == (n_q - CNT_W'(1))) begin
                            state    <= SEND;
                            cap_pend <= 1'b0;
                            word_idx <= '0;
                            byte_idx <= '0;
                        end
                    end
                end

                SEND: begin
                    if (can_issue) begin
                        tx_valid <= 1'b1;
                        tx_data  <= cur_byte;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == gap_lim) begin
                        if (last_byte && last_word) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= SEND;
                            if (last_byte) begin
                                byte_idx <= '0;
                                word_idx <= word_idx + CNT_W'(1);
                            end else begin
                                byte_idx <= byte_idx + BI_W'(1);
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase

            if (rearm) begin
                armed <= 1'b1;
            end
        end
    end

endmodule
